ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative integer multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (forwarded operands plus decoded op). It runs MULT/MULTU/DIV/DIVU over DATA_W iteration cycles, owns the architectural HI/LO registers, and raises a pipeline stall when a younger instruction needs the unit or HI/LO while an operation is in flight.

## Interface
- DATA_W, 32, operand/HI/LO width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- op_valid_i  in  1  multiply/divide instruction present in EX
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data_i  in  DATA_W  forwarded rs operand (multiplicand / dividend)
- rt_data_i  in  DATA_W  forwarded rt operand (multiplier / divisor)
- flush_i  in  1  EX instruction squashed; blocks acceptance this cycle
- hi_rd_i, lo_rd_i  in  1 each  MFHI / MFLO in EX
- hi_wr_i, lo_wr_i  in  1 each  MTHI / MTLO in EX, data on rs_data_i
- hi_o, lo_o  out  DATA_W  HI / LO register contents
- busy_o  out  1  operation in flight (state != IDLE)
- stall_o  out  1  hold IF/ID/EX; combinational
- div_by_zero_o  out  1  one-cycle pulse on the result-write edge of a divide with rt = 0

## Operation
- FSM states: IDLE, RUN, FIX. Reset: state IDLE, hi_o = lo_o = 0, busy_o = 0, div_by_zero_o = 0, iteration counter 0.
- Accept: op_valid_i & !flush_i & IDLE. On accept edge latch op, operand magnitudes (signed ops: two's-complement absolute value), result sign flags; go RUN, counter 0.
- RUN: one radix-2 step per cycle (shift-add multiply; restoring divide, unsigned on magnitudes). After DATA_W steps go FIX.
- FIX: apply sign correction, write HI/LO, go IDLE. MULT: {HI,LO} = 2·DATA_W-bit product, negated if operand signs differ. DIV: LO = quotient (negated if signs differ), HI = remainder (sign of rs).
- Divide by zero (rt = 0, either signedness): LO = all ones, HI = original rs, no sign fix, div_by_zero_o pulses.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0 (wraps, no exception).
- stall_o = busy_o & (op_valid_i | hi_rd_i | lo_rd_i | hi_wr_i | lo_wr_i). Held op is re-presented by the pipeline and accepted on the first IDLE cycle.
- MTHI/MTLO in IDLE write on that edge. Simultaneous with accept: write happens, later FIX overwrites both.
- MFHI/MFLO in IDLE: hi_o/lo_o read directly, no stall.
- flush_i does not abort an operation already in RUN/FIX.
- Reset asserted mid-operation: immediate abort, all outputs to reset values.

## Timing
- Accept edge = edge 0. RUN steps on edges 1..DATA_W; FIX writes HI/LO on edge DATA_W+1; IDLE from then.
- busy_o high for DATA_W+1 cycles after accept edge.
- Back-to-back ops: second op accepted on edge DATA_W+2 at earliest (first IDLE cycle).
- div_by_zero_o high exactly the cycle after the FIX edge.

## Configuration
- MULDIV_DIV_EN defined: full behaviour above.
- Undefined: divider datapath removed; DIV/DIVU are not accepted, never stall on their own, HI/LO unchanged, div_by_zero_o tied 0. MULT/MULTU timing unchanged.

## Structure
- Package muldiv_pkg: DATA_W default, op encoding enum (MULT/MULTU/DIV/DIVU), FSM state enum.
- Sub-module muldiv_sign_fix: combinational absolute value on entry and result negation in FIX, shared by multiply and divide.

## Test plan
- MULT rs=7, rt=0xFFFF_FFFD → after DATA_W+1 edges HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; busy_o high 33 cycles.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001.
- DIV rs=0xFFFF_FFF9 (−7), rt=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; DIV 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- DIVU 100 / 0 → LO=0xFFFF_FFFF, HI=100, div_by_zero_o one-cycle pulse.
- MFLO asserted from cycle 3 after accept → stall_o high until IDLE, then lo_o holds new result; second MULT during busy stalls and is accepted on edge 34.
- rst_i pulsed at RUN step 10 → busy_o=0, stall_o=0, HI=LO=0 immediately; next op completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the EX-stage multiply/divide unit:
//   DATA_W_DEFAULT  default operand / HI / LO width
//   muldiv_op_e     decoded op encoding (MULT, MULTU, DIV, DIVU)
//   muldiv_state_e  iteration FSM states (IDLE, RUN, FIX)
//   op_is_div / op_is_signed  decode helpers on the op encoding
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } muldiv_state_e;

    // Bit 1 of the encoding selects divide, bit 0 selects unsigned.
    function automatic logic op_is_div(input muldiv_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input muldiv_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// -----------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational sign handling shared by multiply and divide.
// Entry side: two's-complement magnitudes of both operands for signed ops.
// Exit side: sign correction of the raw unsigned result in FIX.
//   a, b          in   W   raw rs / rt operands
//   is_signed     in   1   op is MULT or DIV
//   abs_a, abs_b  out  W   operand magnitudes (unchanged for unsigned ops)
//   raw_hi/lo     in   W   unsigned iteration result ({product} or {rem, quot})
//   is_div        in   1   result belongs to a divide
//   neg_prod      in   1   negate the 2W-bit product
//   neg_quot      in   1   negate the quotient
//   neg_rem       in   1   negate the remainder
//   fix_hi/lo     out  W   corrected HI / LO values
// -----------------------------------------------------------------------------
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int W = DATA_W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    output logic [W-1:0] abs_a,
    output logic [W-1:0] abs_b,
    input  logic [W-1:0] raw_hi,
    input  logic [W-1:0] raw_lo,
    input  logic         is_div,
    input  logic         neg_prod,
    input  logic         neg_quot,
    input  logic         neg_rem,
    output logic [W-1:0] fix_hi,
    output logic [W-1:0] fix_lo
);

    logic [2*W-1:0] prod_neg;

    always_comb begin
        // The most negative value maps onto itself, which is the correct
        // unsigned magnitude 2^(W-1).
        abs_a    = (is_signed && a[W-1]) ? -a : a;
        abs_b    = (is_signed && b[W-1]) ? -b : b;
        prod_neg = -{raw_hi, raw_lo};
        fix_hi   = raw_hi;
        fix_lo   = raw_lo;
        if (is_div) begin
            if (neg_rem)  fix_hi = -raw_hi;
            if (neg_quot) fix_lo = -raw_lo;
        end else if (neg_prod) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative radix-2 multiply/divide unit in EX that owns HI/LO. One iteration
// step per cycle for DATA_W cycles, then one FIX cycle that sign-corrects and
// writes HI/LO. Younger instructions touching the unit or HI/LO stall while
// an operation is in flight.
//
// Build option: define MULDIV_DIV_EN to include the divider. Without it,
// DIV/DIVU are ignored (never accepted, never stall), div_by_zero_o is 0.
//
// Ports:
//   clk_i, rst_i           clock, async active-high reset
//   op_valid_i, op_i       mul/div op present in EX and its encoding
//   rs_data_i, rt_data_i   forwarded operands (rs also carries MTHI/MTLO data)
//   flush_i                EX squashed; blocks acceptance this cycle
//   hi_rd_i, lo_rd_i       MFHI / MFLO in EX
//   hi_wr_i, lo_wr_i       MTHI / MTLO in EX
//   hi_o, lo_o             HI / LO contents
//   busy_o                 FSM not IDLE
//   stall_o                hold IF/ID/EX (combinational)
//   div_by_zero_o          one-cycle pulse after FIX of a divide by zero
//
// Handshake: an op is taken on a rising edge where op_valid_i & !flush_i and
// the FSM is IDLE. While busy, any request raises stall_o and the pipeline
// keeps re-presenting it until the first IDLE cycle.
// -----------------------------------------------------------------------------
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              op_valid_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic              flush_i,
    input  logic              hi_rd_i,
    input  logic              lo_rd_i,
    input  logic              hi_wr_i,
    input  logic              lo_wr_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              busy_o,
    output logic              stall_o,
    output logic              div_by_zero_o
);

    localparam int CNT_W = $clog2(DATA_W);

    muldiv_state_e     state, state_nx;
    muldiv_op_e        op_in, op_q;
    logic [DATA_W-1:0] acc;     // product high half / partial remainder
    logic [DATA_W-1:0] mq;      // multiplier -> product low half / dividend -> quotient
    logic [DATA_W-1:0] mcand;   // multiplicand or divisor magnitude
    logic [DATA_W-1:0] hi_q, lo_q;
    logic [CNT_W-1:0]  cnt;
    logic              neg_prod, neg_quot, neg_rem;

    logic              op_ok, accept, last_step;
    logic              in_signed, rs_neg, rt_neg, rt_zero;
    logic [DATA_W-1:0] abs_rs, abs_rt, res_hi, res_lo;
    logic [DATA_W-1:0] step_acc, step_mq;
    logic [DATA_W:0]   mul_sum;

    assign op_in     = muldiv_op_e'(op_i);
    assign in_signed = op_is_signed(op_in);
    assign rs_neg    = in_signed & rs_data_i[DATA_W-1];
    assign rt_neg    = in_signed & rt_data_i[DATA_W-1];
    assign rt_zero   = (rt_data_i == '0);

`ifdef MULDIV_DIV_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~op_is_div(op_in);
`endif

    assign accept    = op_valid_i & ~flush_i & (state == ST_IDLE) & op_ok;
    assign last_step = (cnt == CNT_W'(DATA_W - 1));

    assign busy_o  = (state != ST_IDLE);
    assign stall_o = busy_o & ((op_valid_i & op_ok) | hi_rd_i | lo_rd_i | hi_wr_i | lo_wr_i);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    muldiv_sign_fix #(.W(DATA_W)) u_sign_fix (
        .a         (rs_data_i),
        .b         (rt_data_i),
        .is_signed (in_signed),
        .abs_a     (abs_rs),
        .abs_b     (abs_rt),
        .raw_hi    (acc),
        .raw_lo    (mq),
        .is_div    (op_is_div(op_q)),
        .neg_prod  (neg_prod),
        .neg_quot  (neg_quot),
        .neg_rem   (neg_rem),
        .fix_hi    (res_hi),
        .fix_lo    (res_lo)
    );

    // Shift-add multiply step: {carry, acc, mq} shifts right by one.
    assign mul_sum = {1'b0, acc} + {1'b0, (mq[0] ? mcand : {DATA_W{1'b0}})};

`ifdef MULDIV_DIV_EN
    // Restoring divide step: shift {acc, mq} left, subtract divisor if it fits.
    // The shifted remainder needs one extra bit; when the subtraction succeeds
    // the difference is below the divisor and fits DATA_W bits again.
    logic [DATA_W:0]   rem_sh;
    logic              rem_ge;
    logic [DATA_W-1:0] rem_diff;

    assign rem_sh   = {acc, mq[DATA_W-1]};
    assign rem_ge   = (rem_sh >= {1'b0, mcand});
    assign rem_diff = rem_sh[DATA_W-1:0] - mcand;
`endif

    always_comb begin
        step_acc = mul_sum[DATA_W:1];
        step_mq  = {mul_sum[0], mq[DATA_W-1:1]};
`ifdef MULDIV_DIV_EN
        if (op_is_div(op_q)) begin
            step_acc = rem_ge ? rem_diff : rem_sh[DATA_W-1:0];
            step_mq  = {mq[DATA_W-2:0], rem_ge};
        end
`endif
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_RUN;
            ST_RUN:  if (last_step) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            op_q     <= OP_MULT;
            acc      <= '0;
            mq       <= '0;
            mcand    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt      <= '0;
            neg_prod <= 1'b0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    // MTHI/MTLO land even on an accept edge; FIX overwrites later.
                    if (hi_wr_i) hi_q <= rs_data_i;
                    if (lo_wr_i) lo_q <= rs_data_i;
                    if (accept) begin
                        op_q     <= op_in;
                        cnt      <= '0;
                        acc      <= '0;
                        mq       <= op_is_div(op_in) ? abs_rs : abs_rt;
                        mcand    <= op_is_div(op_in) ? abs_rt : abs_rs;
                        neg_prod <= rs_neg ^ rt_neg;
                        // Divide by zero: the restoring loop yields an all-ones
                        // quotient and |rs| as remainder, so suppressing only the
                        // quotient negation gives LO = ~0 and HI = rs.
                        neg_quot <= (rs_neg ^ rt_neg) & ~rt_zero;
                        neg_rem  <= rs_neg;
                    end
                end
                ST_RUN: begin
                    acc <= step_acc;
                    mq  <= step_mq;
                    cnt <= cnt + CNT_W'(1);
                end
                ST_FIX: begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
                default: ;
            endcase
        end
    end

`ifdef MULDIV_DIV_EN
    logic dbz_q, dbz_pulse;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dbz_q     <= 1'b0;
            dbz_pulse <= 1'b0;
        end else begin
            dbz_pulse <= (state == ST_FIX) & op_is_div(op_q) & dbz_q;
            if (accept) dbz_q <= rt_zero;
        end
    end

    assign div_by_zero_o = dbz_pulse;
`else
    assign div_by_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_ex_muldiv_unit.sv
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

    localparam int DATA_W = 32;

    // ---------------- clock / reset / DUT ----------------
    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              op_valid_i;
    logic [1:0]        op_i;
    logic [DATA_W-1:0] rs_data_i, rt_data_i;
    logic              flush_i, hi_rd_i, lo_rd_i, hi_wr_i, lo_wr_i;
    logic [DATA_W-1:0] hi_o, lo_o;
    logic              busy_o, stall_o, div_by_zero_o;

    always #5 clk_i = ~clk_i;

    ex_muldiv_unit #(.DATA_W(DATA_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .op_valid_i    (op_valid_i),
        .op_i          (op_i),
        .rs_data_i     (rs_data_i),
        .rt_data_i     (rt_data_i),
        .flush_i       (flush_i),
        .hi_rd_i       (hi_rd_i),
        .lo_rd_i       (lo_rd_i),
        .hi_wr_i       (hi_wr_i),
        .lo_wr_i       (lo_wr_i),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .busy_o        (busy_o),
        .stall_o       (stall_o),
        .div_by_zero_o (div_by_zero_o)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_hi, m_lo;
    logic        m_dbz, m_acc;

    task automatic model_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint      sp;
        logic [63:0] wide;
`ifdef MULDIV_DIV_EN
        longint      sq, sr;
`endif
        m_dbz = 1'b0;
        m_acc = 1'b1;
        case (op)
            2'b00: begin
                sp   = longint'($signed(rs)) * longint'($signed(rt));
                wide = sp;
                m_hi = wide[63:32];
                m_lo = wide[31:0];
            end
            2'b01: begin
                wide = {32'b0, rs} * {32'b0, rt};
                m_hi = wide[63:32];
                m_lo = wide[31:0];
            end
            default: begin
`ifdef MULDIV_DIV_EN
                if (rt == 32'd0) begin
                    m_lo  = 32'hFFFF_FFFF;
                    m_hi  = rs;
                    m_dbz = 1'b1;
                end else if (op == 2'b10) begin
                    sq   = longint'($signed(rs)) / longint'($signed(rt));
                    sr   = longint'($signed(rs)) % longint'($signed(rt));
                    wide = sq;
                    m_lo = wide[31:0];
                    wide = sr;
                    m_hi = wide[31:0];
                end else begin
                    m_lo = rs / rt;
                    m_hi = rs % rt;
                end
`else
                m_acc = 1'b0;
`endif
            end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (!busy_o) break;
            n++;
        end
        if (busy_o) check_eq("idle_timeout", busy_o, 1'b0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        int n;
        model_op(op, rs, rt);
        @(negedge clk_i);
        op_valid_i = 1'b1;
        op_i       = op;
        rs_data_i  = rs;
        rt_data_i  = rt;
        @(posedge clk_i);
        #1;
        op_valid_i = 1'b0;
        if (!m_acc) begin
            check_eq("rejected_busy", busy_o, 1'b0);
            check_eq("rejected_hi", hi_o, m_hi);
            check_eq("rejected_lo", lo_o, m_lo);
            return;
        end
        wait_idle(n);
        check_eq("busy_len", n, DATA_W + 1);
        check_eq("res_hi", hi_o, m_hi);
        check_eq("res_lo", lo_o, m_lo);
        check_eq("dbz_pulse", div_by_zero_o, m_dbz);
        @(negedge clk_i);
        check_eq("dbz_clear", div_by_zero_o, 1'b0);
    endtask

    task automatic mt_write(input logic wh, input logic wl, input logic [31:0] v);
        @(negedge clk_i);
        hi_wr_i   = wh;
        lo_wr_i   = wl;
        hi_rd_i   = 1'b1;
        lo_rd_i   = 1'b1;
        rs_data_i = v;
        check_eq("idle_read_nostall", stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        hi_wr_i = 1'b0;
        lo_wr_i = 1'b0;
        hi_rd_i = 1'b0;
        lo_rd_i = 1'b0;
        if (wh) m_hi = v;
        if (wl) m_lo = v;
        check_eq("mt_hi", hi_o, m_hi);
        check_eq("mt_lo", lo_o, m_lo);
    endtask

    task automatic flush_probe(input logic [31:0] v);
        @(negedge clk_i);
        op_valid_i = 1'b1;
        flush_i    = 1'b1;
        op_i       = 2'b00;
        rs_data_i  = v;
        rt_data_i  = ~v;
        @(posedge clk_i);
        #1;
        op_valid_i = 1'b0;
        flush_i    = 1'b0;
        check_eq("flush_busy", busy_o, 1'b0);
        check_eq("flush_hi", hi_o, m_hi);
        check_eq("flush_lo", lo_o, m_lo);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          n, e, stall_cnt, acc_edge;
        logic        seen_idle;
        logic [1:0]  op_r;
        logic [31:0] rs_r, rt_r;

        rst_i = 1'b1;
        op_valid_i = 1'b0; op_i = 2'b00; rs_data_i = '0; rt_data_i = '0;
        flush_i = 1'b0; hi_rd_i = 1'b0; lo_rd_i = 1'b0; hi_wr_i = 1'b0; lo_wr_i = 1'b0;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0; m_acc = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_hi", hi_o, 32'd0);
        check_eq("rst_lo", lo_o, 32'd0);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_stall", stall_o, 1'b0);
        check_eq("rst_dbz", div_by_zero_o, 1'b0);
        rst_i = 1'b0;

        // directed cases
        run_op(2'b00, 32'd7, 32'hFFFF_FFFD);
        check_eq("mult_neg_hi", hi_o, 32'hFFFF_FFFF);
        check_eq("mult_neg_lo", lo_o, 32'hFFFF_FFEB);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("multu_max_hi", hi_o, 32'hFFFF_FFFE);
        check_eq("multu_max_lo", lo_o, 32'h0000_0001);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
`ifdef MULDIV_DIV_EN
        check_eq("div_neg_lo", lo_o, 32'hFFFF_FFFD);
        check_eq("div_neg_hi", hi_o, 32'hFFFF_FFFF);
`endif
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
`ifdef MULDIV_DIV_EN
        check_eq("div_wrap_lo", lo_o, 32'h8000_0000);
        check_eq("div_wrap_hi", hi_o, 32'h0000_0000);
`endif
        run_op(2'b11, 32'd100, 32'd0);
`ifdef MULDIV_DIV_EN
        check_eq("divu_zero_lo", lo_o, 32'hFFFF_FFFF);
        check_eq("divu_zero_hi", hi_o, 32'd100);
`endif
        run_op(2'b10, 32'hFFFF_FF00, 32'd0);

        mt_write(1'b1, 1'b0, 32'hA5A5_0001);
        mt_write(1'b0, 1'b1, 32'h5A5A_0002);
        flush_probe(32'h0000_0033);

        // MTHI on the accept edge: write is visible, then FIX overwrites
        @(negedge clk_i);
        op_valid_i = 1'b1; op_i = 2'b00; rs_data_i = 32'h0000_1234; rt_data_i = 32'h10;
        hi_wr_i = 1'b1;
        @(posedge clk_i);
        #1;
        op_valid_i = 1'b0; hi_wr_i = 1'b0;
        check_eq("mt_accept_hi", hi_o, 32'h0000_1234);
        model_op(2'b00, 32'h0000_1234, 32'h10);
        wait_idle(n);
        check_eq("mt_accept_res_hi", hi_o, m_hi);
        check_eq("mt_accept_res_lo", lo_o, m_lo);

        // MFLO and a second MULT arrive while busy: stall until IDLE
        model_op(2'b00, 32'hFFFF_FFFB, 32'd9);
        @(negedge clk_i);
        op_valid_i = 1'b1; op_i = 2'b00; rs_data_i = 32'hFFFF_FFFB; rt_data_i = 32'd9;
        @(posedge clk_i);
        #1;
        op_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        op_valid_i = 1'b1; lo_rd_i = 1'b1; op_i = 2'b01;
        rs_data_i = 32'h0001_0003; rt_data_i = 32'h0002_0005;
        e = 2; stall_cnt = 0; seen_idle = 1'b0; acc_edge = -1;
        for (int i = 0; i < 100 && acc_edge < 0; i++) begin
            @(negedge clk_i);
            if (busy_o && stall_o) stall_cnt++;
            if (!busy_o && !seen_idle) begin
                seen_idle = 1'b1;
                check_eq("b2b_idle_stall", stall_o, 1'b0);
                check_eq("b2b_first_lo", lo_o, m_lo);
                check_eq("b2b_first_hi", hi_o, m_hi);
            end
            @(posedge clk_i);
            e++;
            #1;
            if (seen_idle && busy_o) acc_edge = e;
        end
        op_valid_i = 1'b0; lo_rd_i = 1'b0;
        check_eq("b2b_stall_cycles", stall_cnt, DATA_W - 1);
        check_eq("b2b_accept_edge", acc_edge, DATA_W + 2);
        model_op(2'b01, 32'h0001_0003, 32'h0002_0005);
        wait_idle(n);
        check_eq("b2b_busy_len", n, DATA_W + 1);
        check_eq("b2b_second_hi", hi_o, m_hi);
        check_eq("b2b_second_lo", lo_o, m_lo);

        // reset in the middle of RUN
        mt_write(1'b1, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk_i);
        op_valid_i = 1'b1; op_i = 2'b01; rs_data_i = 32'h1357_9BDF; rt_data_i = 32'h2468_ACE0;
        @(posedge clk_i);
        #1;
        op_valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #2;
        op_valid_i = 1'b1; lo_rd_i = 1'b1; rst_i = 1'b1;
        #1;
        check_eq("midrst_busy", busy_o, 1'b0);
        check_eq("midrst_stall", stall_o, 1'b0);
        check_eq("midrst_hi", hi_o, 32'd0);
        check_eq("midrst_lo", lo_o, 32'd0);
        op_valid_i = 1'b0; lo_rd_i = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000);
        check_eq("post_rst_hi", hi_o, 32'd1);

        // randomized traffic
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 9))
                0: mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                1: flush_probe($urandom);
                default: begin
                    op_r = 2'($urandom_range(0, 3));
                    rs_r = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
                    case ($urandom_range(0, 7))
                        0:       rt_r = 32'd0;
                        1:       rt_r = 32'hFFFF_FFFF;
                        2:       rt_r = 32'($urandom_range(1, 15));
                        default: rt_r = $urandom;
                    endcase
                    run_op(op_r, rs_r, rt_r);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
